mod_updown_counter: RTL

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_updown_counter.sv | 106 ++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - prescaled modulo up/down counter with wrap pulse and terminal count
// Optional feature: define MOD_UPDOWN_COUNTER_OVF_STICKY_EN to add a sticky overflow flag (ports ovf_clr, ovf).

module mod_updown_counter #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
`ifdef MOD_UPDOWN_COUNTER_OVF_STICKY_EN
  output logic             wrap,
  input  logic             ovf_clr,
  output logic             ovf
`else
  output logic             wrap
`endif
);

  // A 1-bit prescaler is kept even for PRESCALE=1; it simply stays at 0.
  localparam int               PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS = 2**WIDTH is representable for the load clamp.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             step;
  logic [WIDTH-1:0] load_sat;

  assign step     = en && (psc == PSC_MAX);
  assign load_sat = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

  // Next-state: clear beats load beats a prescaled step; direction is only looked at on the step.
  always_comb begin
    count_nxt = count;
    psc_nxt   = psc;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
      psc_nxt   = '0;
    end else if (load) begin
      count_nxt = load_sat;
      psc_nxt   = '0;
    end else if (en) begin
      if (step) begin
        psc_nxt = '0;
        if (up) begin
          if (count == MAX_VAL) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count_nxt = MAX_VAL;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end else begin
        psc_nxt = psc + PSC_W'(1);
      end
    end
  end

  // State registers; reset also discards any partially accumulated prescale period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      psc   <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      psc   <= psc_nxt;
      wrap  <= wrap_nxt;
    end
  end

  // Terminal count follows count and the live direction input with no register stage.
  assign tc = up ? (count == MAX_VAL) : (count == '0);

`ifdef MOD_UPDOWN_COUNTER_OVF_STICKY_EN
  // Sticky overflow: set the cycle after a wrap pulse; a simultaneous wrap wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= wrap | (ovf & ~ovf_clr);
    end
  end
`endif

endmodule
